// File: rtl/dfi_phy_responder.sv
// dfi_phy_responder
//   PHY-side DFI responder that stands in for a real PHY during controller
//   bring-up, FPGA loopback and regression.
//   - Init handshake: dfi_init_start (level) -> dfi_init_complete after
//     C_INIT_CYCLES cycles in the counting state.
//   - Decodes ACT/RD/WR/PRE (REF/MRS/NOP are accepted with no effect) and
//     tracks the open row of each bank.
//   - RD/WR commands queue a storage index. dfi_wrdata_en / dfi_rddata_en
//     consume these indices to write or read a small data array.
//   - Read data returns exactly C_RDLAT cycles after dfi_rddata_en.
//   Ports:
//     core_clk, core_rst          clock, synchronous active-high reset
//     dfi_address/bank/cs_n/ras_n/cas_n/we_n/cke   command bus
//     dfi_wrdata_en/wrdata/wrdata_mask             write data (mask 1 = keep byte)
//     dfi_rddata_en, dfi_rddata, dfi_rddata_valid  read data
//     dfi_init_start, dfi_init_complete            init handshake
//     err_flags                   sticky protocol errors
//   Optional feature: define DFI_RESP_ERRCHK_EN to build the protocol checker.
//   Without it, err_flags is tied to zero.
//
//   state      | meaning
//   WAIT_START | idle after reset; waits for dfi_init_start
//   INIT_CNT   | init timer running; dropping init_start aborts it
//   READY      | init complete; commands are decoded (terminal until reset)
module dfi_phy_responder #(
    parameter int C_DFI_ADDR_WIDTH = 16,
    parameter int C_DFI_BANK_WIDTH = 3,
    parameter int C_DFI_DATA_WIDTH = 128,
    parameter int C_MEM_ADDR_WIDTH = 8,
    parameter int C_RDLAT          = 4,
    parameter int C_INIT_CYCLES    = 16
) (
    input  logic                          core_clk,
    input  logic                          core_rst,
    input  logic [C_DFI_ADDR_WIDTH-1:0]   dfi_address,
    input  logic [C_DFI_BANK_WIDTH-1:0]   dfi_bank,
    input  logic                          dfi_cs_n,
    input  logic                          dfi_ras_n,
    input  logic                          dfi_cas_n,
    input  logic                          dfi_we_n,
    input  logic                          dfi_cke,
    input  logic                          dfi_wrdata_en,
    input  logic [C_DFI_DATA_WIDTH-1:0]   dfi_wrdata,
    input  logic [C_DFI_DATA_WIDTH/8-1:0] dfi_wrdata_mask,
    input  logic                          dfi_rddata_en,
    output logic [C_DFI_DATA_WIDTH-1:0]   dfi_rddata,
    output logic                          dfi_rddata_valid,
    input  logic                          dfi_init_start,
    output logic                          dfi_init_complete,
    output logic [3:0]                    err_flags
);

    localparam int NB  = 2 ** C_DFI_BANK_WIDTH;
    localparam int NW  = 2 ** C_MEM_ADDR_WIDTH;
    localparam int NBY = C_DFI_DATA_WIDTH / 8;
    localparam int CW  = (C_INIT_CYCLES > 1) ? $clog2(C_INIT_CYCLES) : 1;

    typedef enum logic [1:0] {WAIT_START, INIT_CNT, READY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] init_tmr_q;
    logic          init_complete_q;
    logic          ready;

    // ---------------- init FSM ----------------
    // The timer is reloaded whenever the FSM is outside INIT_CNT, so each
    // entry into INIT_CNT starts a full C_INIT_CYCLES countdown.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q         <= WAIT_START;
            init_tmr_q      <= CW'(C_INIT_CYCLES - 1);
            init_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_complete_q <= (state_d == READY);
            if (state_q != INIT_CNT)
                init_tmr_q <= CW'(C_INIT_CYCLES - 1);
            else if (init_tmr_q != '0)
                init_tmr_q <= init_tmr_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_START: if (dfi_init_start) state_d = INIT_CNT;
            INIT_CNT: begin
                if (!dfi_init_start)        state_d = WAIT_START;
                else if (init_tmr_q == '0)  state_d = READY;
            end
            READY:      state_d = READY;
            default:    state_d = WAIT_START;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        if (state_q == READY) ready = 1'b1;
    end

    assign dfi_init_complete = init_complete_q;

    // ---------------- command decode ----------------
    logic                                     cmd_valid;
    logic [2:0]                               cmd;
    logic                                     is_act, is_rd, is_wr, is_pre;
    logic [C_DFI_BANK_WIDTH+C_DFI_ADDR_WIDTH-1:0] cmd_full;
    logic [C_MEM_ADDR_WIDTH-1:0]              cmd_idx;

    assign cmd_valid = ~dfi_cs_n & dfi_cke;
    assign cmd       = {dfi_ras_n, dfi_cas_n, dfi_we_n};
    assign is_act    = cmd_valid & ready & (cmd == 3'b011);
    assign is_rd     = cmd_valid & ready & (cmd == 3'b101);
    assign is_wr     = cmd_valid & ready & (cmd == 3'b100);
    assign is_pre    = cmd_valid & ready & (cmd == 3'b010);
    assign cmd_full  = {dfi_bank, dfi_address};
    assign cmd_idx   = cmd_full[C_MEM_ADDR_WIDTH-1:0];

    // ---------------- bank table ----------------
    logic [NB-1:0]               bank_open;
    logic [C_DFI_ADDR_WIDTH-1:0] bank_row [NB];

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            bank_open <= '0;
        end else if (is_act) begin
            bank_open[dfi_bank] <= 1'b1;
        end else if (is_pre) begin
            if (dfi_address[10]) bank_open <= '0;
            else                 bank_open[dfi_bank] <= 1'b0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (is_act) bank_row[dfi_bank] <= dfi_address;
    end

    // ---------------- index FIFOs (depth 4) ----------------
    // A push into a full FIFO is accepted when a pop happens the same cycle.
    logic [C_MEM_ADDR_WIDTH-1:0] rf_mem [4];
    logic [C_MEM_ADDR_WIDTH-1:0] wf_mem [4];
    logic [1:0] rf_wp, rf_rp, wf_wp, wf_rp;
    logic [2:0] rf_cnt, wf_cnt;
    logic       rf_pop, rf_push, wf_pop, wf_push;

    assign rf_pop  = dfi_rddata_en & (rf_cnt != 3'd0);
    assign rf_push = is_rd & ((rf_cnt != 3'd4) | rf_pop);
    assign wf_pop  = dfi_wrdata_en & (wf_cnt != 3'd0);
    assign wf_push = is_wr & ((wf_cnt != 3'd4) | wf_pop);

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            rf_wp  <= '0;
            rf_rp  <= '0;
            rf_cnt <= '0;
            wf_wp  <= '0;
            wf_rp  <= '0;
            wf_cnt <= '0;
        end else begin
            if (rf_push) rf_wp <= rf_wp + 2'd1;
            if (rf_pop)  rf_rp <= rf_rp + 2'd1;
            if (wf_push) wf_wp <= wf_wp + 2'd1;
            if (wf_pop)  wf_rp <= wf_rp + 2'd1;
            rf_cnt <= rf_cnt + {2'b00, rf_push} - {2'b00, rf_pop};
            wf_cnt <= wf_cnt + {2'b00, wf_push} - {2'b00, wf_pop};
        end
    end

    always_ff @(posedge core_clk) begin
        if (rf_push) rf_mem[rf_wp] <= cmd_idx;
        if (wf_push) wf_mem[wf_wp] <= cmd_idx;
    end

    // ---------------- data array ----------------
    logic [C_DFI_DATA_WIDTH-1:0] mem [NW];
    logic [C_MEM_ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic [C_DFI_DATA_WIDTH-1:0] rd_word;

    assign wr_idx = wf_mem[wf_rp];
    assign rd_idx = rf_mem[rf_rp];

    always_ff @(posedge core_clk) begin
        if (wf_pop) begin
            for (int b = 0; b < NBY; b++) begin
                if (!dfi_wrdata_mask[b])
                    mem[wr_idx][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
            end
        end
    end

    // Write-first: a read launched alongside a write to the same word sees
    // the bytes being written this cycle.
    always_comb begin
        rd_word = '0;
        if (rf_pop) begin
            rd_word = mem[rd_idx];
            for (int b = 0; b < NBY; b++) begin
                if (wf_pop && (wr_idx == rd_idx) && !dfi_wrdata_mask[b])
                    rd_word[b*8 +: 8] = dfi_wrdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read latency pipeline ----------------
    logic [C_DFI_DATA_WIDTH-1:0] pipe_data  [C_RDLAT];
    logic                        pipe_valid [C_RDLAT];

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            for (int i = 0; i < C_RDLAT; i++) begin
                pipe_data[i]  <= '0;
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            for (int i = C_RDLAT - 1; i > 0; i--) begin
                pipe_data[i]  <= pipe_data[i-1];
                pipe_valid[i] <= pipe_valid[i-1];
            end
            pipe_data[0]  <= rd_word;
            pipe_valid[0] <= dfi_rddata_en;
        end
    end

    assign dfi_rddata       = pipe_data[C_RDLAT-1];
    assign dfi_rddata_valid = pipe_valid[C_RDLAT-1];

    // ---------------- protocol checker ----------------
`ifdef DFI_RESP_ERRCHK_EN
    logic [3:0] err_q;
    logic [3:0] err_set;

    always_comb begin
        err_set    = '0;
        err_set[0] = is_act & bank_open[dfi_bank];
        err_set[1] = (is_rd | is_wr) & ~bank_open[dfi_bank];
        err_set[2] = cmd_valid & ~ready & (cmd != 3'b111);
        err_set[3] = (is_rd & ~rf_push) | (is_wr & ~wf_push)
                   | (dfi_rddata_en & (rf_cnt == 3'd0))
                   | (dfi_wrdata_en & (wf_cnt == 3'd0));
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) err_q <= '0;
        else          err_q <= err_q | err_set;
    end

    assign err_flags = err_q;
`else
    assign err_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_dfi_phy_responder.sv
// Directed bench for dfi_phy_responder: init handshake, write/read paths,
// masking, write-first bypass, FIFO limits, error flags and reset abort.
module tb_dfi_phy_responder;

`ifdef DFI_RESP_ERRCHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;

    localparam logic [127:0] D7  = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] D10 = {{15{8'h11}}, 8'h22};
    localparam logic [127:0] D30 = {{8{8'h55}}, {8{8'hAA}}};

    logic         core_clk = 1'b0;
    logic         core_rst;
    logic [15:0]  dfi_address;
    logic [2:0]   dfi_bank;
    logic         dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cke;
    logic         dfi_wrdata_en;
    logic [127:0] dfi_wrdata;
    logic [15:0]  dfi_wrdata_mask;
    logic         dfi_rddata_en;
    logic [127:0] dfi_rddata;
    logic         dfi_rddata_valid;
    logic         dfi_init_start;
    logic         dfi_init_complete;
    logic [3:0]   err_flags;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q [5];

    dfi_phy_responder dut (
        .core_clk          (core_clk),
        .core_rst          (core_rst),
        .dfi_address       (dfi_address),
        .dfi_bank          (dfi_bank),
        .dfi_cs_n          (dfi_cs_n),
        .dfi_ras_n         (dfi_ras_n),
        .dfi_cas_n         (dfi_cas_n),
        .dfi_we_n          (dfi_we_n),
        .dfi_cke           (dfi_cke),
        .dfi_wrdata_en     (dfi_wrdata_en),
        .dfi_wrdata        (dfi_wrdata),
        .dfi_wrdata_mask   (dfi_wrdata_mask),
        .dfi_rddata_en     (dfi_rddata_en),
        .dfi_rddata        (dfi_rddata),
        .dfi_rddata_valid  (dfi_rddata_valid),
        .dfi_init_start    (dfi_init_start),
        .dfi_init_complete (dfi_init_complete),
        .err_flags         (err_flags)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] rcw, input logic [2:0] b, input logic [15:0] a);
        dfi_cs_n = 1'b0;
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = rcw;
        dfi_bank = b;
        dfi_address = a;
        @(negedge core_clk);
        dfi_cs_n = 1'b1;
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
    endtask

    task automatic wdata(input logic [127:0] d, input logic [15:0] m);
        dfi_wrdata_en = 1'b1;
        dfi_wrdata = d;
        dfi_wrdata_mask = m;
        @(negedge core_clk);
        dfi_wrdata_en = 1'b0;
    endtask

    // one rddata_en pulse; beat must appear on the 4th edge, not before/after
    task automatic rd_check(input string tag, input logic [127:0] exp);
        dfi_rddata_en = 1'b1;
        @(negedge core_clk);
        dfi_rddata_en = 1'b0;
        repeat (2) @(negedge core_clk);
        chk({tag, "_early"}, {127'd0, dfi_rddata_valid}, 128'd0);
        @(negedge core_clk);
        chk({tag, "_valid"}, {127'd0, dfi_rddata_valid}, 128'd1);
        chk({tag, "_data"}, dfi_rddata, exp);
        @(negedge core_clk);
        chk({tag, "_after"}, {127'd0, dfi_rddata_valid}, 128'd0);
    endtask

    // five back-to-back rddata_en; optionally a RD b2 col 0x10 in the first cycle
    task automatic burst5(input string tag, input bit with_cmd);
        dfi_rddata_en = 1'b1;
        if (with_cmd) begin
            dfi_cs_n = 1'b0;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} = C_RD;
            dfi_bank = 3'd2;
            dfi_address = 16'h0010;
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge core_clk);
            dfi_cs_n = 1'b1;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
            if (i == 4) dfi_rddata_en = 1'b0;
            if (i >= 3 && i <= 7) begin
                chk($sformatf("%s_v%0d", tag, i - 3), {127'd0, dfi_rddata_valid}, 128'd1);
                chk($sformatf("%s_d%0d", tag, i - 3), dfi_rddata, exp_q[i-3]);
            end else begin
                chk($sformatf("%s_idle%0d", tag, i), {127'd0, dfi_rddata_valid}, 128'd0);
            end
        end
    endtask

    initial begin
        bit seen_valid;
        core_rst = 1'b1;
        dfi_address = '0;
        dfi_bank = '0;
        dfi_cs_n = 1'b1;
        dfi_ras_n = 1'b1;
        dfi_cas_n = 1'b1;
        dfi_we_n = 1'b1;
        dfi_cke = 1'b1;
        dfi_wrdata_en = 1'b0;
        dfi_wrdata = '0;
        dfi_wrdata_mask = '0;
        dfi_rddata_en = 1'b0;
        dfi_init_start = 1'b0;
        repeat (3) @(negedge core_clk);
        core_rst = 1'b0;
        @(negedge core_clk);

        chk("rst_init_complete", {127'd0, dfi_init_complete}, 128'd0);
        chk("rst_valid", {127'd0, dfi_rddata_valid}, 128'd0);
        chk("rst_rddata", dfi_rddata, 128'd0);
        chk("rst_err", {124'd0, err_flags}, 128'd0);

        // command before READY: ignored, flagged by checker
        cmd(C_ACT, 3'd0, 16'h0000);
        chk("pre_ready_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b0100 : 4'b0000)});

        // init aborted at cycle 5
        dfi_init_start = 1'b1;
        repeat (5) @(negedge core_clk);
        dfi_init_start = 1'b0;
        repeat (20) @(negedge core_clk);
        chk("init_abort", {127'd0, dfi_init_complete}, 128'd0);

        // full init: edge 0 samples start, complete after edge 16
        dfi_init_start = 1'b1;
        repeat (16) @(negedge core_clk);
        chk("init_edge15", {127'd0, dfi_init_complete}, 128'd0);
        @(negedge core_clk);
        chk("init_edge16", {127'd0, dfi_init_complete}, 128'd1);

        // basic write / read
        cmd(C_ACT, 3'd2, 16'h01A5);
        cmd(C_WR, 3'd2, 16'h0007);
        wdata(D7, 16'h0000);
        cmd(C_RD, 3'd2, 16'h0007);
        rd_check("wr_rd", D7);

        // partial write: only byte 0 updated
        cmd(C_WR, 3'd2, 16'h0010);
        wdata({16{8'h11}}, 16'h0000);
        cmd(C_WR, 3'd2, 16'h0010);
        wdata({16{8'h22}}, 16'hFFFE);
        cmd(C_RD, 3'd2, 16'h0010);
        rd_check("mask", D10);

        // write-first bypass with mask: upper 8 bytes new, lower 8 old
        cmd(C_WR, 3'd2, 16'h0030);
        wdata({16{8'hAA}}, 16'h0000);
        cmd(C_WR, 3'd2, 16'h0030);
        cmd(C_RD, 3'd2, 16'h0030);
        dfi_wrdata_en = 1'b1;
        dfi_wrdata = {16{8'h55}};
        dfi_wrdata_mask = 16'h00FF;
        rd_check("bypass", D30);
        dfi_wrdata_en = 1'b0;

        // 5 RDs into depth-4 FIFO: 5th dropped; 5th rddata_en pops empty -> zero beat
        cmd(C_RD, 3'd2, 16'h0007);
        cmd(C_RD, 3'd2, 16'h0010);
        cmd(C_RD, 3'd2, 16'h0030);
        cmd(C_RD, 3'd2, 16'h0007);
        cmd(C_RD, 3'd2, 16'h0010);
        chk("overflow_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b1100 : 4'b0000)});
        exp_q[0] = D7;
        exp_q[1] = D10;
        exp_q[2] = D30;
        exp_q[3] = D7;
        exp_q[4] = 128'd0;
        burst5("drop", 1'b0);

        // push and pop in the same cycle while full: nothing lost
        cmd(C_RD, 3'd2, 16'h0007);
        cmd(C_RD, 3'd2, 16'h0010);
        cmd(C_RD, 3'd2, 16'h0030);
        cmd(C_RD, 3'd2, 16'h0007);
        exp_q[4] = D10;
        burst5("full_pp", 1'b1);

        // error flags
        cmd(C_ACT, 3'd0, 16'h0001);
        chk("act_first_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b1100 : 4'b0000)});
        cmd(C_ACT, 3'd0, 16'h0002);
        chk("act_open_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b1101 : 4'b0000)});
        cmd(C_RD, 3'd3, 16'h0007);
        chk("rd_closed_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b1111 : 4'b0000)});
        cmd(C_PRE, 3'd0, 16'h0400);
        cmd(C_RD, 3'd0, 16'h0010);
        chk("pre_all_err", {124'd0, err_flags}, {124'd0, (ERR_ON ? 4'b1111 : 4'b0000)});
        rd_check("closed_rd0", D7);
        rd_check("closed_rd1", D10);

        // reset with two reads in flight
        cmd(C_RD, 3'd2, 16'h0007);
        cmd(C_RD, 3'd2, 16'h0007);
        dfi_rddata_en = 1'b1;
        repeat (2) @(negedge core_clk);
        dfi_rddata_en = 1'b0;
        core_rst = 1'b1;
        @(negedge core_clk);
        core_rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge core_clk);
            if (dfi_rddata_valid) seen_valid = 1'b1;
        end
        chk("rst_abort_valid", {127'd0, seen_valid}, 128'd0);
        chk("rst_abort_complete", {127'd0, dfi_init_complete}, 128'd0);
        chk("rst_abort_err", {124'd0, err_flags}, 128'd0);
        chk("rst_abort_rddata", dfi_rddata, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
